// File: rtl/kmp_pkg.sv
// Shared definitions for the KMP byte-stream transmitter: buffer geometry and FSM states.
package kmp_pkg;

  localparam int STRING_SIZE = 2241;
  localparam int AW          = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } kmp_state_e;

endpackage

// File: rtl/kmp_str_ram.sv
// String buffer: one write port, one registered read port, contents never reset.
module kmp_str_ram
  import kmp_pkg::*;
#(
  parameter int DEPTH  = STRING_SIZE,
  parameter int ADDR_W = AW
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/kmp_stream_tx.sv
// Streams bytes 0..len-1 of the string buffer to the matcher through a 2-entry skid buffer.
// state  | meaning
// IDLE   | host may write the buffer; waiting for a valid start
// PRIME  | read of address 0 issued, first byte arrives next cycle
// STREAM | reads issued on credit, bytes handed to the consumer
// DONE   | one-cycle completion pulse, then back to IDLE
module kmp_stream_tx
  import kmp_pkg::*;
#(
  parameter int STRING_SIZE = kmp_pkg::STRING_SIZE,
  parameter int AW          = kmp_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done,
  output logic          err_len,
  output logic [31:0]   bytes_sent
);

  localparam logic [AW-1:0] SIZE_A = AW'(STRING_SIZE);
  localparam logic [AW-1:0] ONE_A  = AW'(1);

  kmp_state_e    state_q, state_d;
  logic [AW-1:0] len_q, len_d, rd_ptr_q, rd_ptr_d;
  logic          rd_vld_q, rd_last_q;
  logic [7:0]    skid_data_q [2];
  logic [7:0]    skid_data_d [2];
  logic          skid_last_q [2];
  logic          skid_last_d [2];
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic [31:0]   bytes_q, bytes_d;
  logic          err_q;

  logic          len_ok, accept, ram_we, rd_go, pop;
  logic [7:0]    ram_rdata;
  logic [2:0]    occ;

  assign len_ok = (len != '0) && (len <= SIZE_A);
  assign accept = (state_q == ST_IDLE) && start && len_ok;
  assign ram_we = wr_en && (state_q == ST_IDLE) && !accept && (wr_addr < SIZE_A);

  // Head of the stream: oldest skid entry, else the RAM output register bypassed straight out.
  assign out_valid = (skid_cnt_q != 2'd0) || rd_vld_q;
  assign out_data  = (skid_cnt_q != 2'd0) ? skid_data_q[0] : (rd_vld_q ? ram_rdata : 8'h00);
  assign out_last  = (skid_cnt_q != 2'd0) ? skid_last_q[0] : (rd_vld_q & rd_last_q);
  assign pop       = out_valid && out_ready;

  // A read may issue only if, after this cycle's pop, at most one byte is held or in flight.
  assign occ   = {1'b0, skid_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign rd_go = ((state_q == ST_PRIME) || (state_q == ST_STREAM)) &&
                 (rd_ptr_q < len_q) && (occ <= 3'd1);

  kmp_str_ram #(.DEPTH(STRING_SIZE), .ADDR_W(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_go),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    bytes_d  = bytes_q;
    if (rd_go) rd_ptr_d = rd_ptr_q + ONE_A;
    if (pop)   bytes_d  = bytes_q + 32'd1;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d  = ST_PRIME;
        len_d    = len;
        rd_ptr_d = '0;
        bytes_d  = '0;
      end
      ST_PRIME:  state_d = ST_STREAM;
      ST_STREAM: if (pop && out_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_cnt_d  = skid_cnt_q;
    if (pop && (skid_cnt_q != 2'd0)) begin
      skid_data_d[0] = skid_data_q[1];
      skid_last_d[0] = skid_last_q[1];
      skid_cnt_d     = skid_cnt_q - 2'd1;
    end
    if (rd_vld_q && !(pop && (skid_cnt_q == 2'd0))) begin
      skid_data_d[skid_cnt_d[0]] = ram_rdata;
      skid_last_d[skid_cnt_d[0]] = rd_last_q;
      skid_cnt_d                 = skid_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      rd_ptr_q       <= '0;
      rd_vld_q       <= 1'b0;
      rd_last_q      <= 1'b0;
      skid_data_q[0] <= 8'h00;
      skid_data_q[1] <= 8'h00;
      skid_last_q[0] <= 1'b0;
      skid_last_q[1] <= 1'b0;
      skid_cnt_q     <= 2'd0;
      bytes_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_vld_q    <= rd_go;
      rd_last_q   <= rd_go && (rd_ptr_q == (len_q - ONE_A));
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_cnt_q  <= skid_cnt_d;
      bytes_q     <= bytes_d;
      err_q       <= (state_q == ST_IDLE) && start && !len_ok;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err_len    = err_q;
  assign bytes_sent = bytes_q;

endmodule

// File: doc/kmp_stream_tx.md
KMP_STREAM_TX -- requirements
Module: kmp_stream_tx

Interface
REQ-001 The block SHALL have parameter STRING_SIZE, default 2241: buffer depth in bytes.
REQ-002 The block SHALL have parameter AW, default 12: address and length width, with 2^AW > STRING_SIZE.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en, wr_addr, wr_data  input  1/AW/8  host byte write into the string buffer.
REQ-006 start, len  input  1/AW  one-cycle start pulse and byte count to stream from address 0.
REQ-007 busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-008 out_valid, out_data, out_last  output  1/8/1  byte stream toward the matcher's input port.
REQ-009 out_ready  input  1  consumer ready; a byte transfers on any cycle with out_valid and out_ready both high.
REQ-010 done, err_len  output  1/1  one-cycle pulses: stream complete, or start rejected.
REQ-011 bytes_sent  output  32  count of transferred bytes in the current or last run.

Function
REQ-012 The block SHALL accept wr_en writes only when busy is low.
- Writes with wr_addr >= STRING_SIZE SHALL be dropped silently.
REQ-013 The state machine SHALL have states IDLE, PRIME, STREAM and DONE.
REQ-014 In IDLE, start with 1 <= len <= STRING_SIZE SHALL:
- latch len;
- clear bytes_sent;
- raise busy next cycle;
- go to PRIME.
REQ-015 In IDLE, start with len==0 or len > STRING_SIZE SHALL pulse err_len the next cycle and stay in IDLE.
REQ-016 start SHALL be ignored when busy is high.
REQ-017 PRIME SHALL issue the read for address 0; the buffer read latency is 1 cycle.
- The first out_valid SHALL assert exactly 2 cycles after start.
REQ-018 A 2-entry output skid buffer SHALL sit behind the buffer read.
- Reads SHALL issue only when a free entry is guaranteed.
- With out_ready held high, throughput SHALL be one byte per cycle.
REQ-019 While out_valid is high and out_ready is low, out_data and out_last SHALL hold stable.
- out_valid SHALL NOT deassert until the byte transfers.
REQ-020 Bytes SHALL be emitted in address order 0..len-1.
- out_last SHALL be high only with byte len-1.
REQ-021 bytes_sent SHALL increment by 1 on each transfer, in the cycle after the transfer.
REQ-022 The transfer of the out_last byte SHALL move the FSM to DONE.
- out_valid SHALL be low the next cycle.
REQ-023 DONE SHALL last one cycle, with done=1 and busy=1, then return to IDLE with busy=0.
REQ-024 A host write in the same cycle as an accepted start SHALL be dropped.
REQ-025 out_valid SHALL never be high outside PRIME and STREAM.

Reset
REQ-026 Asserting rst_n low at any time, including mid-stream, SHALL drive all of the following to 0 immediately:
- state = IDLE;
- busy, out_valid, out_data, out_last;
- done, err_len;
- bytes_sent, read pointer, skid entries.
REQ-027 Buffer contents SHALL NOT be reset; after reset they are undefined until written.

Structure
REQ-028 The shared package kmp_pkg SHALL hold:
- the state enum;
- STRING_SIZE;
- AW.
REQ-029 The string buffer SHALL be a separate sub-module, kmp_str_ram:
- simple dual-port, one write port and one read port;
- registered read, no reset.
REQ-030 The FSM, read pointer, skid buffer and counter SHALL live in kmp_stream_tx.

Verification
REQ-031 Write "ABAB" to addresses 0..3, start len=4, out_ready=1 -> the bench SHALL check:
- bytes 41,42,41,42 on 4 consecutive cycles starting 2 cycles after start;
- out_last with the 4th byte;
- done one cycle later;
- bytes_sent=4.
REQ-032 Same as REQ-031 but out_ready toggling 1,0,0,1,0,1... -> the bench SHALL check:
- data held stable while stalled;
- no byte lost or duplicated;
- bytes_sent=4.
REQ-033 start len=0, then len=2242 -> the bench SHALL check:
- err_len pulses each time;
- busy, out_valid and done stay 0.
REQ-034 Full run with len=2241 into kmp4 with pattern "ABAB" and buffer holding "ABABAB" then filler 'Z' -> the bench SHALL check:
- matcher n_matches=2;
- bytes_sent=2241.
REQ-035 rst_n low at byte 100 of a len=500 run, then restart len=3 -> the bench SHALL check:
- outputs are 0 during reset;
- the new run emits buffer bytes 0..2 with out_last on byte 2.
REQ-036 Start pulsed while busy, and wr_en asserted while busy -> the bench SHALL check:
- both are ignored;
- the stream and buffer contents are unchanged.
